// File: rtl/hazard_scoreboard_if.sv
// Decode-stage bundle between the issuing decoder (master) and hazard_scoreboard (slave):
// the decode instruction, pipeline control, and the stall/forwarding decision.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  two_src;
  logic                  issue_valid;
  logic                  issue_wb_en;
  logic                  issue_mem_r_en;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic                  freeze;
  logic                  flush;
  logic                  hazard_detected;
  logic [3:0]            fwd_sel1;
  logic [3:0]            fwd_sel2;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output src1, src2, two_src, issue_valid, issue_wb_en, issue_mem_r_en, issue_dest,
    output freeze, flush,
    input  hazard_detected, fwd_sel1, fwd_sel2, stall_count
  );

  modport slave (
    input  src1, src2, two_src, issue_valid, issue_wb_en, issue_mem_r_en, issue_dest,
    input  freeze, flush,
    output hazard_detected, fwd_sel1, fwd_sel2, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writebacks and flags decode-stage RAW hazards.
// Define HAZARD_FORWARDING_EN to stall only on load-use and forward everything else.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      load_q, load_d;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [REG_ADDR_W-1:0] dest_d [DEPTH];
  logic [CNT_W-1:0]      stall_q, stall_d;

  logic [DEPTH-1:0]      match1, match2;
  logic                  hazard;
  logic [3:0]            fwd1, fwd2;

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      match1[k] = valid_q[k] && (dest_q[k] == bus.src1);
      match2[k] = bus.two_src && valid_q[k] && (dest_q[k] == bus.src2);
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; everything else bypasses.
  always_comb begin
    hazard = bus.issue_valid && load_q[0] && (match1[0] || match2[0]);
    fwd1   = '0;
    fwd2   = '0;
    if (bus.issue_valid && !hazard) begin
      // Descending scan so the youngest matching stage wins.
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (match1[k]) fwd1 = 4'(k + 1);
        if (match2[k]) fwd2 = 4'(k + 1);
      end
    end
  end
`else
  assign hazard = bus.issue_valid && ((|match1) || (|match2));
  assign fwd1   = '0;
  assign fwd2   = '0;
`endif

  assign bus.hazard_detected = hazard;
  assign bus.fwd_sel1        = fwd1;
  assign bus.fwd_sel2        = fwd2;
  assign bus.stall_count     = stall_q;

  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    dest_d  = dest_q;
    stall_d = stall_q;
    if (!bus.freeze) begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      // A stalled or squashed instruction leaves a bubble behind it.
      valid_d[0] = bus.issue_valid && bus.issue_wb_en && !hazard && !bus.flush;
      load_d[0]  = bus.issue_mem_r_en;
      dest_d[0]  = bus.issue_dest;
      if (hazard && (stall_q != '1)) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      stall_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      stall_q <= stall_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard; two DUTs (DEPTH=2/CNT_W=16 and
// DEPTH=8/CNT_W=2) share stimulus and are checked against a queue-style reference model.
module tb_hazard_scoreboard;

  localparam int unsigned RW = 4;
  localparam int          NM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ADDR_W(RW), .CNT_W(16)) bus ();
  hazard_scoreboard_if #(.REG_ADDR_W(RW), .CNT_W(2))  bus_s ();

  hazard_scoreboard #(.REG_ADDR_W(RW), .DEPTH(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hazard_scoreboard #(.REG_ADDR_W(RW), .DEPTH(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus_s.src1           = bus.src1;
  assign bus_s.src2           = bus.src2;
  assign bus_s.two_src        = bus.two_src;
  assign bus_s.issue_valid    = bus.issue_valid;
  assign bus_s.issue_wb_en    = bus.issue_wb_en;
  assign bus_s.issue_mem_r_en = bus.issue_mem_r_en;
  assign bus_s.issue_dest     = bus.issue_dest;
  assign bus_s.freeze         = bus.freeze;
  assign bus_s.flush          = bus.flush;

  // Reference model: per DUT, a list of in-flight writes, youngest first.
  typedef struct {
    bit v;
    int d;
    bit l;
  } ent_t;

  int unsigned m_depth [NM] = '{32'd2, 32'd8};
  int unsigned m_max   [NM] = '{32'd65535, 32'd3};
  ent_t        pipe    [NM][8];
  int unsigned m_cnt   [NM];
  bit          e_haz   [NM];
  int          e_f1    [NM];
  int          e_f2    [NM];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset(int i);
    for (int k = 0; k < 8; k++) pipe[i][k] = '{v: 1'b0, d: 0, l: 1'b0};
    m_cnt[i] = 0;
  endfunction

  function automatic void model_eval(int i);
    int k1;
    int k2;
    k1 = -1;
    k2 = -1;
    e_haz[i] = 1'b0;
    e_f1[i]  = 0;
    e_f2[i]  = 0;
    if (!bus.issue_valid) return;
    for (int k = 0; k < int'(m_depth[i]); k++) begin
      if (k1 < 0 && pipe[i][k].v && pipe[i][k].d == int'(bus.src1)) k1 = k;
      if (k2 < 0 && bus.two_src && pipe[i][k].v && pipe[i][k].d == int'(bus.src2)) k2 = k;
    end
`ifdef HAZARD_FORWARDING_EN
    e_haz[i] = (k1 == 0 || k2 == 0) && pipe[i][0].l;
    if (!e_haz[i]) begin
      e_f1[i] = k1 + 1;
      e_f2[i] = k2 + 1;
    end
`else
    e_haz[i] = (k1 >= 0) || (k2 >= 0);
`endif
  endfunction

  function automatic void model_update(int i);
    if (bus.freeze) return;
    if (e_haz[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
    for (int k = int'(m_depth[i]) - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
    pipe[i][0].v = bus.issue_valid && bus.issue_wb_en && !e_haz[i] && !bus.flush;
    pipe[i][0].d = int'(bus.issue_dest);
    pipe[i][0].l = bus.issue_mem_r_en;
  endfunction

  task automatic drive(input logic [RW-1:0] s1, input logic [RW-1:0] s2, input logic two,
                       input logic v, input logic wb, input logic ld,
                       input logic [RW-1:0] dst, input logic frz, input logic fl);
    bus.src1           = s1;
    bus.src2           = s2;
    bus.two_src        = two;
    bus.issue_valid    = v;
    bus.issue_wb_en    = wb;
    bus.issue_mem_r_en = ld;
    bus.issue_dest     = dst;
    bus.freeze         = frz;
    bus.flush          = fl;
  endtask

  // Entered 1 time unit after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    #2;
    for (int i = 0; i < NM; i++) begin
      if (rst) model_reset(i);
      model_eval(i);
    end
    check_eq({tag, "/haz"},   32'(bus.hazard_detected),   32'(e_haz[0]));
    check_eq({tag, "/fwd1"},  32'(bus.fwd_sel1),          32'(e_f1[0]));
    check_eq({tag, "/fwd2"},  32'(bus.fwd_sel2),          32'(e_f2[0]));
    check_eq({tag, "/cnt"},   32'(bus.stall_count),       m_cnt[0]);
    check_eq({tag, "/haz8"},  32'(bus_s.hazard_detected), 32'(e_haz[1]));
    check_eq({tag, "/fwd1_8"}, 32'(bus_s.fwd_sel1),       32'(e_f1[1]));
    check_eq({tag, "/fwd2_8"}, 32'(bus_s.fwd_sel2),       32'(e_f2[1]));
    check_eq({tag, "/cnt_sat"}, 32'(bus_s.stall_count),   m_cnt[1]);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NM; i++) model_update(i);
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NM; i++) model_reset(i);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cycle("reset");
    cycle("reset");
    rst = 1'b0;

    // Write R3, then a reader of R3 held in decode for three cycles.
    drive(0, 0, 0, 1, 1, 0, 3, 0, 0);
    cycle("iss_r3");
    drive(3, 3, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) cycle("use_r3");
`ifdef HAZARD_FORWARDING_EN
    check_eq("r3_stall_total", 32'(bus.stall_count), 32'd0);
`else
    check_eq("r3_stall_total", 32'(bus.stall_count), 32'd2);
`endif

    // Load R5 then a second-operand use; then the same register as a non-operand.
    drive(0, 0, 0, 1, 1, 1, 5, 0, 0);
    cycle("ldr_r5");
    drive(9, 5, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) cycle("use_r5");
    drive(9, 5, 0, 1, 0, 0, 0, 0, 0);
    cycle("r5_one_src");

    // Load R7 then freeze for three cycles with a reader in decode.
    drive(0, 0, 0, 1, 1, 1, 7, 0, 0);
    cycle("ldr_r7");
    drive(7, 0, 0, 1, 0, 0, 0, 1, 0);
    repeat (3) cycle("frz_r7");
    drive(7, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) cycle("thaw_r7");

    // Squashed write of R4 leaves nothing to depend on.
    drive(0, 0, 0, 1, 1, 0, 4, 0, 1);
    cycle("flush_r4");
    drive(4, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle("use_r4");

    // Reset pulse in the middle of a stall.
    drive(0, 0, 0, 1, 1, 1, 6, 0, 0);
    cycle("ldr_r6");
    drive(6, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle("stall_r6");
    rst = 1'b1;
    cycle("rst_mid");
    rst = 1'b0;

    // Five writes of R1, then five stalled readers: the 2-bit counter must saturate.
    drive(0, 0, 0, 1, 1, 0, 1, 0, 0);
    repeat (5) cycle("iss_r1");
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (5) cycle("sat_r1");
`ifndef HAZARD_FORWARDING_EN
    check_eq("cnt_sat_final", 32'(bus_s.stall_count), 32'd3);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) cycle("drain");

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) == 0);
      drive(RW'($urandom_range(3)), RW'($urandom_range(3)), 1'($urandom_range(1)),
            ($urandom_range(9) != 0), 1'($urandom_range(1)), ($urandom_range(2) == 0),
            RW'($urandom_range(3)), ($urandom_range(4) == 0), ($urandom_range(9) == 0));
      cycle("rand");
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REG_ADDR_W, default 4: register-address width (16 ARM registers).
REQ-002 SHALL provide parameter DEPTH, default 2: number of in-flight writeback stages tracked (2 = EXE, MEM); legal range 1..8.
REQ-003 SHALL provide parameter CNT_W, default 16: stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 src1  input  REG_ADDR_W  first source register of the instruction in decode.
REQ-007 src2  input  REG_ADDR_W  second source register.
REQ-008 two_src  input  1  src2 is a real operand.
REQ-009 issue_valid  input  1  decode holds a valid instruction.
REQ-010 issue_wb_en  input  1  decode instruction writes a register.
REQ-011 issue_mem_r_en  input  1  decode instruction is a load.
REQ-012 issue_dest  input  REG_ADDR_W  decode instruction destination.
REQ-013 freeze  input  1  pipeline-wide hold (memory wait).
REQ-014 flush  input  1  branch taken; decode instruction is squashed.
REQ-015 hazard_detected  output  1  stall decode this cycle.
REQ-016 fwd_sel1  output  4  forwarding source for src1: 0 = register file, k = tracked stage k-1.
REQ-017 fwd_sel2  output  4  same for src2.
REQ-018 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-019 SHALL hold DEPTH registered entries e[0..DEPTH-1] of {valid, dest, load}; e[0] youngest (EXE), e[DEPTH-1] oldest.
REQ-020 match(s,k) SHALL be e[k].valid && e[k].dest == s; src2 matches only when two_src=1.
REQ-021 hazard_detected, fwd_sel1, fwd_sel2 SHALL be combinational from inputs and registered entries (zero-cycle latency) and SHALL be 0 when issue_valid=0.
REQ-022 On a rising edge with freeze=0, entries SHALL shift e[k] <= e[k-1]; e[DEPTH-1] is discarded.
REQ-023 With freeze=0, e[0] SHALL load {1, issue_dest, issue_mem_r_en} when issue_valid && issue_wb_en && !hazard_detected && !flush; otherwise e[0] SHALL become invalid (bubble).
REQ-024 With freeze=1, all entries SHALL hold regardless of flush; hazard outputs SHALL still be evaluated.
REQ-025 stall_count SHALL increment by 1 on each edge where hazard_detected=1 and freeze=0, saturating at 2^CNT_W-1 (no wrap).
REQ-026 A stalled instruction SHALL be re-evaluated every cycle; hazard_detected clears once the matching entry shifts out or a bubble separates it.
REQ-027 Same dest in several entries: youngest (lowest k) SHALL govern forwarding.

Reset
REQ-028 While rst=1, all entries SHALL be invalid and stall_count 0, asynchronously; hazard_detected, fwd_sel1, fwd_sel2 consequently read 0.
REQ-029 Reset asserted mid-stall SHALL drop the stall immediately; first edge after release resumes normal shifting.

Configuration
REQ-030 Macro HAZARD_FORWARDING_EN SHALL select the hazard policy.
REQ-031 Without HAZARD_FORWARDING_EN: hazard_detected = any match(src1,k) or match(src2,k) over all k; fwd_sel1 = fwd_sel2 = 0 constantly.
REQ-032 With HAZARD_FORWARDING_EN: hazard_detected only when match at k=0 and e[0].load=1 (load-use); otherwise fwd_selN = 1 + lowest matching k, else 0; fwd_selN SHALL be 0 while hazard_detected=1.

Verification
REQ-033 Default params, no macro: issue R3 write, next cycle src1=3 -> hazard_detected=1 for 2 cycles, then 0; stall_count=2.
REQ-034 Macro on: ADD R3 then src1=3, src2=3, two_src=1 -> hazard_detected=0, fwd_sel1=fwd_sel2=1; one cycle later fwd_sel1=2.
REQ-035 Macro on: LDR R5 then src2=5, two_src=1 -> hazard_detected=1 one cycle, then fwd_sel2=2; src2=5 with two_src=0 -> no hazard.
REQ-036 freeze=1 three cycles with R7 in e[0] and src1=7 -> entries held, stall_count unchanged, hazard_detected stays 1.
REQ-037 flush=1 while issuing R4 write -> next cycle src1=4 sees no hazard; rst pulse mid-stall -> hazard_detected=0 and stall_count=0 immediately.
REQ-038 CNT_W=2, continuous hazard 5 unfrozen cycles -> stall_count 1,2,3,3,3.
